// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel-fetch interface and aligned RGB output.
// Optional frame counter port enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned H_FP        = 16,
   parameter int unsigned H_SYNC      = 96,
   parameter int unsigned H_BP        = 48,
   parameter int unsigned V_ACTIVE    = 480,
   parameter int unsigned V_FP        = 10,
   parameter int unsigned V_SYNC      = 2,
   parameter int unsigned V_BP        = 33,
   parameter bit          H_SYNC_POL  = 1'b0,
   parameter bit          V_SYNC_POL  = 1'b0,
   parameter int unsigned PRESCALE    = 1,
   parameter int unsigned PIX_LATENCY = 1,
   parameter int unsigned COLOR_W     = 4,
   parameter int unsigned CW          = 11
) (
   input  logic                 clk_25_175,
   input  logic                 reset,
   output logic [CW-1:0]        hpos,
   output logic [CW-1:0]        vpos,
   output logic                 req,
   input  logic [3*COLOR_W-1:0] pixstream,
   output logic [COLOR_W-1:0]   r,
   output logic [COLOR_W-1:0]   g,
   output logic [COLOR_W-1:0]   b,
   output logic                 h_sync,
   output logic                 v_sync,
   output logic                 drawing_pixels,
   output logic                 line_start,
`ifdef VGA_TIMING_FRAME_CNT_EN
   output logic [15:0]          frame_cnt,
`endif
   output logic                 frame_start
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PW-1:0] ph_q, ph_d;
   logic [CW-1:0] hpos_q, hpos_d;
   logic [CW-1:0] vpos_q, vpos_d;
   logic          ph_last, h_last, v_last;

   assign ph_last = (ph_q == PW'(PRESCALE - 1));
   assign h_last  = (hpos_q == CW'(H_TOTAL - 1));
   assign v_last  = (vpos_q == CW'(V_TOTAL - 1));

   always_comb begin
      ph_d   = ph_last ? '0 : ph_q + PW'(1);
      hpos_d = hpos_q;
      vpos_d = vpos_q;
      if (ph_last) begin
         hpos_d = h_last ? '0 : hpos_q + CW'(1);
         if (h_last) begin
            vpos_d = v_last ? '0 : vpos_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_25_175 or posedge reset) begin
      if (reset) begin
         ph_q   <= '0;
         hpos_q <= '0;
         vpos_q <= '0;
      end else begin
         ph_q   <= ph_d;
         hpos_q <= hpos_d;
         vpos_q <= vpos_d;
      end
   end

   assign hpos = hpos_q;
   assign vpos = vpos_q;

   // Gated by reset so the pulses read 0 while held in reset.
   assign line_start  = !reset && (hpos_q == '0) && (ph_q == '0);
   assign frame_start = line_start && (vpos_q == '0);

   logic req_raw, hs_raw, vs_raw;

   assign req_raw = (hpos_q < CW'(H_ACTIVE)) && (vpos_q < CW'(V_ACTIVE));
   assign req     = req_raw;
   assign hs_raw  = ((hpos_q >= CW'(H_ACTIVE + H_FP)) && (hpos_q < CW'(H_ACTIVE + H_FP + H_SYNC)))
                    ? H_SYNC_POL : !H_SYNC_POL;
   assign vs_raw  = ((vpos_q >= CW'(V_ACTIVE + V_FP)) && (vpos_q < CW'(V_ACTIVE + V_FP + V_SYNC)))
                    ? V_SYNC_POL : !V_SYNC_POL;

   logic req_dly, hs_dly, vs_dly;

   generate
      if (PIX_LATENCY == 0) begin : g_no_pipe
         assign req_dly = req_raw;
         assign hs_dly  = hs_raw;
         assign vs_dly  = vs_raw;
      end else begin : g_pipe
         logic [PIX_LATENCY-1:0] req_pipe_q, req_pipe_d;
         logic [PIX_LATENCY-1:0] hs_pipe_q, hs_pipe_d;
         logic [PIX_LATENCY-1:0] vs_pipe_q, vs_pipe_d;

         always_comb begin
            req_pipe_d    = req_pipe_q;
            hs_pipe_d     = hs_pipe_q;
            vs_pipe_d     = vs_pipe_q;
            req_pipe_d[0] = req_raw;
            hs_pipe_d[0]  = hs_raw;
            vs_pipe_d[0]  = vs_raw;
            for (int i = 1; i < int'(PIX_LATENCY); i++) begin
               req_pipe_d[i] = req_pipe_q[i-1];
               hs_pipe_d[i]  = hs_pipe_q[i-1];
               vs_pipe_d[i]  = vs_pipe_q[i-1];
            end
         end

         always_ff @(posedge clk_25_175 or posedge reset) begin
            if (reset) begin
               req_pipe_q <= '0;
               hs_pipe_q  <= {PIX_LATENCY{!H_SYNC_POL}};
               vs_pipe_q  <= {PIX_LATENCY{!V_SYNC_POL}};
            end else begin
               req_pipe_q <= req_pipe_d;
               hs_pipe_q  <= hs_pipe_d;
               vs_pipe_q  <= vs_pipe_d;
            end
         end

         assign req_dly = req_pipe_q[PIX_LATENCY-1];
         assign hs_dly  = hs_pipe_q[PIX_LATENCY-1];
         assign vs_dly  = vs_pipe_q[PIX_LATENCY-1];
      end
   endgenerate

   logic [3*COLOR_W-1:0] rgb_q, rgb_d;
   logic                 hs_q, hs_d, vs_q, vs_d, de_q, de_d;

   always_comb begin
      rgb_d = req_dly ? pixstream : '0;
      hs_d  = hs_dly;
      vs_d  = vs_dly;
      de_d  = req_dly;
   end

   always_ff @(posedge clk_25_175 or posedge reset) begin
      if (reset) begin
         rgb_q <= '0;
         hs_q  <= !H_SYNC_POL;
         vs_q  <= !V_SYNC_POL;
         de_q  <= 1'b0;
      end else begin
         rgb_q <= rgb_d;
         hs_q  <= hs_d;
         vs_q  <= vs_d;
         de_q  <= de_d;
      end
   end

   assign r              = rgb_q[COLOR_W-1:0];
   assign g              = rgb_q[2*COLOR_W-1:COLOR_W];
   assign b              = rgb_q[3*COLOR_W-1:2*COLOR_W];
   assign h_sync         = hs_q;
   assign v_sync         = vs_q;
   assign drawing_pixels = de_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;

   always_comb begin
      frame_cnt_d = frame_start ? frame_cnt_q + 16'd1 : frame_cnt_q;
   end

   always_ff @(posedge clk_25_175 or posedge reset) begin
      if (reset) begin
         frame_cnt_q <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen in a tiny raster mode with random colours and random
// asynchronous resets; frame_cnt is checked when VGA_TIMING_FRAME_CNT_EN is defined.
module tb_vga_timing_gen;

   localparam int HA = 4, HF = 1, HSY = 2, HB = 1;
   localparam int VA = 3, VF = 1, VSY = 1, VB = 1;
   localparam int HT = HA + HF + HSY + HB;
   localparam int VT = VA + VF + VSY + VB;
   localparam int PS = 2;
   localparam int LAT = 2;
   localparam int CWB = 4;
   localparam int COLW = 4;
   localparam bit HPOL = 1'b1;
   localparam bit VPOL = 1'b0;
   localparam int FRAME = HT * VT * PS;

   typedef struct {
      int h, v, rq, ls, fs, hs, vs, de, rgb, fc;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [CWB-1:0]    hpos, vpos;
   logic              req;
   logic [3*COLW-1:0] pixstream;
   logic [COLW-1:0]   r, g, b;
   logic              h_sync, v_sync, drawing_pixels, line_start, frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [15:0]       frame_cnt;
`endif

   int errors = 0;
   int checks = 0;
   int k = 0;
   exp_t q[$];
   logic [3*COLW-1:0] tbl [HT][VT];
   logic [CWB-1:0] sh [LAT];
   logic [CWB-1:0] sv [LAT];

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
      .H_SYNC_POL(HPOL), .V_SYNC_POL(VPOL),
      .PRESCALE(PS), .PIX_LATENCY(LAT), .COLOR_W(COLW), .CW(CWB)
   ) dut (
      .clk_25_175(clk),
      .reset(rst),
      .hpos(hpos),
      .vpos(vpos),
      .req(req),
      .pixstream(pixstream),
      .r(r),
      .g(g),
      .b(b),
      .h_sync(h_sync),
      .v_sync(v_sync),
      .drawing_pixels(drawing_pixels),
      .line_start(line_start),
`ifdef VGA_TIMING_FRAME_CNT_EN
      .frame_cnt(frame_cnt),
`endif
      .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   // Pixel source with LAT clocks of latency: looks up the coordinate requested LAT clocks ago.
   initial begin
      for (int i = 0; i < LAT; i++) begin
         sh[i] = '0;
         sv[i] = '0;
      end
   end
   always @(posedge clk) begin
      sh[0] <= hpos;
      sv[0] <= vpos;
      for (int i = 1; i < LAT; i++) begin
         sh[i] <= sh[i-1];
         sv[i] <= sv[i-1];
      end
   end
   assign pixstream = tbl[sh[LAT-1]][sv[LAT-1]];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (k=%0d)", name, act, exp, k);
      end
   endtask

   // Expected observables after k clock edges since reset release.
   function automatic exp_t model(input int kk);
      exp_t e;
      int p, ph, j, h2, v2;
      bit act;
      p    = kk / PS;
      ph   = kk % PS;
      e.h  = p % HT;
      e.v  = (p / HT) % VT;
      e.rq = (e.h < HA && e.v < VA) ? 1 : 0;
      e.ls = (e.h == 0 && ph == 0) ? 1 : 0;
      e.fs = (e.ls == 1 && e.v == 0) ? 1 : 0;
      j    = kk - (LAT + 1);
      if (j < 0) begin
         e.de  = 0;
         e.hs  = int'(!HPOL);
         e.vs  = int'(!VPOL);
         e.rgb = 0;
      end else begin
         p     = j / PS;
         h2    = p % HT;
         v2    = (p / HT) % VT;
         act   = (h2 < HA) && (v2 < VA);
         e.de  = act ? 1 : 0;
         e.hs  = (h2 >= HA + HF && h2 < HA + HF + HSY) ? int'(HPOL) : int'(!HPOL);
         e.vs  = (v2 >= VA + VF && v2 < VA + VF + VSY) ? int'(VPOL) : int'(!VPOL);
         e.rgb = act ? int'(tbl[h2][v2]) : 0;
      end
      e.fc = (kk == 0) ? 0 : (((kk - 1) / FRAME + 1) % 65536);
      return e;
   endfunction

   // Reference side: one expected entry per clock edge out of reset.
   always @(posedge clk) begin
      if (!rst) begin
         k = k + 1;
         q.push_back(model(k));
      end
   end

   // Monitor: the DUT presents a full output set every clock.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("hpos", int'(hpos), e.h);
         chk("vpos", int'(vpos), e.v);
         chk("req", int'(req), e.rq);
         chk("line_start", int'(line_start), e.ls);
         chk("frame_start", int'(frame_start), e.fs);
         chk("h_sync", int'(h_sync), e.hs);
         chk("v_sync", int'(v_sync), e.vs);
         chk("drawing_pixels", int'(drawing_pixels), e.de);
         chk("rgb", int'({b, g, r}), e.rgb);
`ifdef VGA_TIMING_FRAME_CNT_EN
         chk("frame_cnt", int'(frame_cnt), e.fc);
`endif
      end
   end

   task automatic check_reset_vals(input string tag);
      chk({tag, "_hpos"}, int'(hpos), 0);
      chk({tag, "_vpos"}, int'(vpos), 0);
      chk({tag, "_line_start"}, int'(line_start), 0);
      chk({tag, "_frame_start"}, int'(frame_start), 0);
      chk({tag, "_h_sync"}, int'(h_sync), int'(!HPOL));
      chk({tag, "_v_sync"}, int'(v_sync), int'(!VPOL));
      chk({tag, "_drawing_pixels"}, int'(drawing_pixels), 0);
      chk({tag, "_rgb"}, int'({b, g, r}), 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
      chk({tag, "_frame_cnt"}, int'(frame_cnt), 0);
`endif
   endtask

   initial begin
      int run_len;
      for (int h = 0; h < HT; h++) begin
         for (int v = 0; v < VT; v++) begin
            tbl[h][v] = 12'($urandom_range(1, 4095));
         end
      end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_vals("por");
      rst = 1'b0;
      for (int seg = 0; seg < 6; seg++) begin
         run_len = (seg == 5) ? 3 * FRAME + 17 : int'($urandom_range(20, 2 * FRAME));
         repeat (run_len) @(posedge clk);
         @(negedge clk);
         #($urandom_range(1, 3));
         rst = 1'b1;
         #1;
         check_reset_vals("async");
         q.delete();
         k = 0;
         repeat (int'($urandom_range(1, 2))) @(posedge clk);
         @(negedge clk);
         rst = 1'b0;
      end
      repeat (FRAME + 5) @(posedge clk);
      #2;
      chk("queue_drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
